axil_fifo_rd: RTL

AXI-lite read-only slave that drains a local receive FIFO. An internal producer pushes words with a push/data interface; an AXI-lite master reads them out.
- Read of DATA address: pops the head word.
- Read of STATUS address: returns occupancy and flags.
- Sits beside the AXI-lite write-to-FIFO block as the return path, e.g. core-side readback of peripheral or accelerator results.

---
 rtl/axil_fifo_rd_pkg.sv | 25 ++
 rtl/axil_fifo_rd_if.sv | 25 ++
 rtl/axil_fifo_rd_sync_fifo_cnt.sv | 69 ++++++
 rtl/axil_fifo_rd.sv | 138 +++++++++++++
 4 files changed

// File: rtl/axil_fifo_rd_pkg.sv
// axil_fifo_pkg: shared constants and types for the AXI-lite FIFO read slave.
//   - AXI read response codes
//   - register offsets relative to MEM_BASE
//   - STATUS word bit positions
//   - read-channel FSM state type
package axil_fifo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned OFS_DATA   = 0;
    localparam int unsigned OFS_STATUS = 4;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 8;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axil_fifo_rd_if.sv
// axil_fifo_rd_if: AXI-lite read channels (AR + R) only.
//   master modport: drives araddr/arvalid/rready
//   slave modport : drives arready/rdata/rresp/rvalid
interface axil_fifo_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;
    logic                  axi_rvalid;
    logic                  axi_rready;

    modport master (
        output axi_araddr, axi_arvalid, axi_rready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_rready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axil_fifo_rd_sync_fifo_cnt.sv
// sync_fifo_cnt: circular-buffer FIFO with occupancy counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   psh, din    : push strobe and data (dropped while full unless popping)
//   pop         : pop strobe (ignored while empty)
//   dout        : head word, combinational
//   count       : occupancy 0..DEPTH
//   full, empty : derived from count
//   ovf_pulse   : high in a cycle where a push is being dropped
module sync_fifo_cnt #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             psh,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             ovf_pulse
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             psh_ok, pop_ok;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign dout      = mem_q[rd_ptr_q];
    assign pop_ok    = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is kept.
    assign psh_ok    = psh && (!full || pop_ok);
    assign ovf_pulse = psh && !psh_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (psh_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({psh_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (psh_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/axil_fifo_rd.sv
// axil_fifo_rd: AXI-lite read-only slave draining a local receive FIFO.
//   clk, rst_n         : clock, synchronous active-low reset
//   fif_psh, fif_din   : producer push strobe / data
//   fif_full           : FIFO full, pushes while high are dropped
//   axi (slave modport): AR and R channels
// Reads of MEM_BASE pop the head word; MEM_BASE+4 returns
// {count[15:8], overflow, full, empty} and clears the overflow sticky.
// Build option AXIL_FIFO_RD_BLOCK_EN: a DATA read on an empty FIFO is
// stalled on AR until data arrives instead of answering SLVERR.
//
// state   | meaning
// RD_IDLE | arready high, waiting for an AR handshake
// RD_RESP | response registered, rvalid high until rready
module axil_fifo_rd
    import axil_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE   = 32'h1000_0000,
    parameter int                    DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fif_psh,
    input  logic [DATA_WIDTH-1:0] fif_din,
    output logic                  fif_full,
    axil_fifo_rd_if.slave         axi
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = MEM_BASE + ADDR_WIDTH'(OFS_DATA);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = MEM_BASE + ADDR_WIDTH'(OFS_STATUS);

    rd_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] head;
    logic [CNT_W-1:0]      count;
    logic                  full, empty, ovf_pulse;
    logic                  is_data, is_status, block_ar, arready, ar_hs, pop;
    logic [DATA_WIDTH-1:0] status_word;

    sync_fifo_cnt #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .psh       (fif_psh),
        .din       (fif_din),
        .pop       (pop),
        .dout      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ovf_pulse (ovf_pulse)
    );

    assign is_data   = (axi.axi_araddr == ADDR_DATA);
    assign is_status = (axi.axi_araddr == ADDR_STATUS);

`ifdef AXIL_FIFO_RD_BLOCK_EN
    assign block_ar = axi.axi_arvalid && is_data && empty;
`else
    assign block_ar = 1'b0;
`endif

    // Gated by rst_n so arready is low during reset regardless of state_q.
    assign arready = rst_n && (state_q == RD_IDLE) && !block_ar;
    assign ar_hs   = axi.axi_arvalid && arready;
    assign pop     = ar_hs && is_data && !empty;

    always_comb begin
        status_word                        = '0;
        status_word[ST_CNT_LSB +: CNT_W]   = count;
        status_word[ST_OVF]                = ovf_q;
        status_word[ST_FULL]               = full;
        status_word[ST_EMPTY]              = empty;
    end

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rvalid_d = rvalid_q;
        // A dropped push sets the sticky even when a STATUS read clears it.
        ovf_d    = ovf_pulse ? 1'b1 : ((ar_hs && is_status) ? 1'b0 : ovf_q);
        case (state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    if (is_data) begin
                        rdata_d = empty ? '0 : head;
                        rresp_d = empty ? RESP_SLVERR : RESP_OKAY;
                    end else if (is_status) begin
                        rdata_d = status_word;
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_DECERR;
                    end
                end
            end
            RD_RESP: begin
                if (axi.axi_rready) begin
                    state_d  = RD_IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = RD_IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RD_IDLE;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign axi.axi_arready = arready;
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_rvalid  = rvalid_q;
    assign fif_full        = full;
endmodule
